canny_window_sequencer: RTL and testbench
=========================================

// Module: canny_window_sequencer
// PURPOSE
// Scans an IMG_W x IMG_H 8-bit image held in an external pixel memory and walks a
// 5x5 window over every valid centre. For each window it loads the 25 pixels into
// the Canny edge engine (regX), pulses one operation, and reads back the result.
// Each result is presented on a valid/ready stream tagged with its centre (x,y).
// Sits between the image memory / testbench and the CannyEdge datapath.
// PARAMETERS
// IMG_W       32  image width in pixels (>=5)
// IMG_H       32  image height in pixels (>=5)
// DATA_WIDTH  8   pixel/result width
// OP_CYCLES   4   cycles bOPEnable is held low per window (>=2)
// PORTS
// clk         in   1   clock, all logic on rising edge
// rst         in   1   synchronous, active-high reset
// start       in   1   1-cycle pulse; begins a frame when idle, ignored when busy
// op_mode     in   3   engine mode (0 gauss,1 sobel,2 nms,3 hyst), latched at start
// busy        out  1   high from the cycle after accepted start until done
// done        out  1   1-cycle pulse after the last result is accepted
// mem_addr    out  16  pixel address = row*IMG_W+col
// mem_rd      out  1   read strobe; mem_data valid exactly 1 cycle later
// mem_data    in   8   pixel read data
// dAddrRegRow out  3   engine window row 0..4
// dAddrRegCol out  3   engine window column 0..4
// bWE, bCE    out  1   engine strobes, active low
// InData      out  8   engine write data
// OutData     in   8   engine result, registered by engine on read cycle
// OPMode      out  3   = latched op_mode
// bOPEnable   out  1   engine operation enable, active low
// dReadReg    out  4   result select: mode 0->0, 1->1, 2->3, 3->4
// dWriteReg   out  4   constant 0 (regX)
// res_valid   out  1   result available
// res_ready   in   1   consumer accepts when res_valid&&res_ready
// res_data    out  8   engine result
// res_x,res_y out  8   window centre column/row
// BEHAVIOUR
// - Reset: state IDLE; busy,done,mem_rd,res_valid=0; bCE=bWE=bOPEnable=1;
//   addresses, InData, res_* = 0; centre = (2,2). Reset mid-frame aborts at once.
// - Centres: x 2..IMG_W-3 (inner, fastest), y 2..IMG_H-3; (IMG_W-4)*(IMG_H-4) results.
// - IDLE: on start latch op_mode, centre=(2,2), go LOAD.
// - LOAD, k=0..25 (26 cycles): k<25 issues mem_rd, addr of pixel
//   r=k/5,c=k%5 at (cy-2+r, cx-2+c); k>=1 drives bCE=0,bWE=0,InData=mem_data,
//   Row/Col of pixel k-1. Last cycle (k=25) writes only.
// - RUN: bCE=1,bWE=1, bOPEnable=0 for OP_CYCLES cycles.
// - RELEASE: 1 cycle, bOPEnable=1 (clears engine sub-state).
// - READ: 1 cycle, bCE=0,bWE=1, Row/Col=2/2 (nms reads regX[12]).
// - CAPT: 1 cycle, res_data<=OutData, res_x/res_y<=centre, res_valid<=1.
// - OUT: hold res_* stable until res_ready; on handshake res_valid=0; if last
//   centre -> DONE else advance centre (x wrap to 2, y+1) -> LOAD.
// - DONE: done=1 one cycle, busy=0 -> IDLE.
// - Per-window period = 26+OP_CYCLES+3 cycles + OUT wait (min 1).
// - Never bCE=0 while bOPEnable=0; mem_rd only in LOAD.
// - Address arithmetic 16 bit; IMG_W*IMG_H must fit.
// TESTING (bench uses stub engine: stores writes, returns stored regX[12] on read)
// - 5x5 image p=r*5+c, mode 0, res_ready=1 -> one result 12 at (2,2), done 34 cycles after LOAD start+1.
// - 6x6 image p=r*6+c -> results 14,15,20,21 at (2,2),(3,2),(2,3),(3,3), then done.
// - res_ready low 10 cycles on first result -> res_* held stable, no new LOAD until accept.
// - start while busy -> ignored, op_mode unchanged, result count unchanged.
// - rst in RUN -> next cycle bOPEnable=1, bCE=1, busy=0, res_valid=0; new start rescans from (2,2).
// - op_mode 2 -> OPMode=2, dReadReg=3; op_mode 3 -> dReadReg=4; dWriteReg always 0.

Source files
------------

// File: rtl/canny_window_sequencer.sv
// Walks a 5x5 window over every valid image centre, feeds the pixels to the
// Canny engine, runs one operation and streams the tagged result out.
module canny_window_sequencer #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int DATA_WIDTH = 8,
    parameter int OP_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op_mode,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [2:0]            dAddrRegRow,
    output logic [2:0]            dAddrRegCol,
    output logic                  bWE,
    output logic                  bCE,
    output logic [DATA_WIDTH-1:0] InData,
    input  logic [DATA_WIDTH-1:0] OutData,
    output logic [2:0]            OPMode,
    output logic                  bOPEnable,
    output logic [3:0]            dReadReg,
    output logic [3:0]            dWriteReg,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [7:0]            res_x,
    output logic [7:0]            res_y
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_READ = 3'd4;
    localparam logic [2:0] S_CAPT = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam int         OCW    = $clog2(OP_CYCLES + 1);
    localparam logic [7:0] X_LAST = 8'(IMG_W - 3);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 3);

    logic [2:0]            state_q, state_d;
    logic [4:0]            k_q, k_d;
    logic [2:0]            rd_r_q, rd_r_d, rd_c_q, rd_c_d;
    logic [2:0]            wr_r_q, wr_r_d, wr_c_q, wr_c_d;
    logic [OCW-1:0]        op_q, op_d;
    logic [7:0]            cx_q, cx_d, cy_q, cy_d;
    logic [2:0]            mode_q, mode_d;
    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic [7:0]            rx_q, rx_d, ry_q, ry_d;

    logic        load_rd, load_wr;
    logic [15:0] pix_row, pix_col;

    // Reads run one cycle ahead of the matching engine write.
    assign load_rd = (state_q == S_LOAD) && (k_q < 5'd25);
    assign load_wr = (state_q == S_LOAD) && (k_q != 5'd0);
    assign pix_row = 16'(cy_q) + 16'(rd_r_q) - 16'd2;
    assign pix_col = 16'(cx_q) + 16'(rd_c_q) - 16'd2;

    assign mem_rd      = load_rd;
    assign mem_addr    = load_rd ? pix_row * 16'(IMG_W) + pix_col : 16'd0;
    assign bCE         = !(load_wr || state_q == S_READ);
    assign bWE         = !load_wr;
    assign bOPEnable   = (state_q != S_RUN);
    assign InData      = load_wr ? mem_data : '0;
    assign dAddrRegRow = load_wr ? wr_r_q : (state_q == S_READ) ? 3'd2 : 3'd0;
    assign dAddrRegCol = load_wr ? wr_c_q : (state_q == S_READ) ? 3'd2 : 3'd0;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign OPMode      = mode_q;
    assign dWriteReg   = 4'd0;
    assign res_valid   = rv_q;
    assign res_data    = rdat_q;
    assign res_x       = rx_q;
    assign res_y       = ry_q;

    always_comb begin
        case (mode_q)
            3'd1:    dReadReg = 4'd1;
            3'd2:    dReadReg = 4'd3;
            3'd3:    dReadReg = 4'd4;
            default: dReadReg = 4'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rd_r_d  = rd_r_q;
        rd_c_d  = rd_c_q;
        wr_r_d  = wr_r_q;
        wr_c_d  = wr_c_q;
        op_d    = op_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        mode_d  = mode_q;
        rv_d    = rv_q;
        rdat_d  = rdat_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = op_mode;
                    cx_d    = 8'd2;
                    cy_d    = 8'd2;
                    k_d     = 5'd0;
                    rd_r_d  = 3'd0;
                    rd_c_d  = 3'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                k_d    = k_q + 5'd1;
                wr_r_d = rd_r_q;
                wr_c_d = rd_c_q;
                if (rd_c_q == 3'd4) begin
                    rd_c_d = 3'd0;
                    rd_r_d = rd_r_q + 3'd1;
                end else begin
                    rd_c_d = rd_c_q + 3'd1;
                end
                if (k_q == 5'd25) begin
                    op_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                op_d = op_q + 1'b1;
                if (op_q == OCW'(OP_CYCLES - 1)) state_d = S_REL;
            end
            S_REL:  state_d = S_READ;
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                rdat_d  = OutData;
                rx_d    = cx_q;
                ry_d    = cy_q;
                rv_d    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    rv_d = 1'b0;
                    if (cx_q == X_LAST && cy_q == Y_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        if (cx_q == X_LAST) begin
                            cx_d = 8'd2;
                            cy_d = cy_q + 8'd1;
                        end else begin
                            cx_d = cx_q + 8'd1;
                        end
                        k_d     = 5'd0;
                        rd_r_d  = 3'd0;
                        rd_c_d  = 3'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            rd_r_q  <= '0;
            rd_c_q  <= '0;
            wr_r_q  <= '0;
            wr_c_q  <= '0;
            op_q    <= '0;
            cx_q    <= 8'd2;
            cy_q    <= 8'd2;
            mode_q  <= '0;
            rv_q    <= 1'b0;
            rdat_q  <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rd_r_q  <= rd_r_d;
            rd_c_q  <= rd_c_d;
            wr_r_q  <= wr_r_d;
            wr_c_q  <= wr_c_d;
            op_q    <= op_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            mode_q  <= mode_d;
            rv_q    <= rv_d;
            rdat_q  <= rdat_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

endmodule

// File: tb/tb_canny_window_sequencer.sv
// Bench for canny_window_sequencer: random images, memory and engine stubs,
// window-checksum reference model and directed protocol scenarios.
module tb_canny_window_sequencer;

    localparam int W   = 8;
    localparam int H   = 7;
    localparam int NR  = (W - 4) * (H - 4);
    localparam int OPC = 4;
    localparam int WIN = 26 + OPC + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op_mode = 3'd0;
    logic        busy, done, mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'd0;
    logic [2:0]  dAddrRegRow, dAddrRegCol, OPMode;
    logic        bWE, bCE, bOPEnable;
    logic [7:0]  InData;
    logic [7:0]  OutData = 8'd0;
    logic [3:0]  dReadReg, dWriteReg;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  res_data, res_x, res_y;

    always #5 clk = ~clk;

    canny_window_sequencer #(
        .IMG_W(W), .IMG_H(H), .DATA_WIDTH(8), .OP_CYCLES(OPC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op_mode(op_mode),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .dAddrRegRow(dAddrRegRow),
        .dAddrRegCol(dAddrRegCol), .bWE(bWE), .bCE(bCE), .InData(InData),
        .OutData(OutData), .OPMode(OPMode), .bOPEnable(bOPEnable),
        .dReadReg(dReadReg), .dWriteReg(dWriteReg), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_x(res_x),
        .res_y(res_y)
    );

    typedef struct {
        int x;
        int y;
        int d;
    } res_t;

    logic [7:0] img [W*H];
    logic [7:0] eregs [25];
    res_t       obs [$];
    int total = 0, passed = 0, fails = 0;
    int oob = 0, prot = 0;

    // Stub engine returns a position-weighted sum so every window slot matters.
    function automatic logic [7:0] csum();
        int s = 0;
        for (int i = 0; i < 25; i++) s += int'(eregs[i]) * (i + 1);
        return 8'(s);
    endfunction

    function automatic int model(input int x, input int y);
        int s = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s += int'(img[(y - 2 + r) * W + (x - 2 + c)]) * (r * 5 + c + 1);
        return s % 256;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) begin
            if (int'(mem_addr) < W * H) mem_data <= img[mem_addr];
            else begin
                mem_data <= 8'hEE;
                oob <= oob + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!bCE && !bWE && dAddrRegRow < 3'd5 && dAddrRegCol < 3'd5)
            eregs[int'(dAddrRegRow) * 5 + int'(dAddrRegCol)] <= InData;
        if (!bCE && bWE) OutData <= csum();
    end

    always @(negedge clk) begin
        if (!bCE && !bOPEnable) prot <= prot + 1;
        if (mem_rd && !busy) prot <= prot + 1;
        if (!rst && res_valid && res_ready)
            obs.push_back('{int'(res_x), int'(res_y), int'(res_data)});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic fill_img();
        for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
    endtask

    task automatic pulse_start(input logic [2:0] m);
        op_mode = m;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            step();
            cyc++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_results(input int base, input string tg);
        int idx = 0;
        chk({tg, "_count"}, 32'(obs.size() - base), 32'(NR));
        for (int y = 2; y <= H - 3; y++)
            for (int x = 2; x <= W - 3; x++) begin
                if (base + idx < obs.size())
                    chk({tg, "_res"},
                        {8'(obs[base+idx].x), 8'(obs[base+idx].y),
                         8'(obs[base+idx].d)},
                        {8'(x), 8'(y), 8'(model(x, y))});
                idx++;
            end
    endtask

    initial begin
        int cyc, base, n;
        logic [7:0] sx, sy, sd;

        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strobes", {mem_rd, res_valid, bCE, bWE, bOPEnable},
            {27'd0, 5'b00111});
        chk("rst_addr", {mem_addr, InData}, 32'd0);
        chk("rst_res", {res_x, res_y, res_data}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Frame 1: gauss, always ready, exact frame latency.
        fill_img();
        base = obs.size();
        res_ready = 1'b1;
        pulse_start(3'd0);
        chk("f1_busy", 32'(busy), 32'd1);
        chk("f1_first_rd", {mem_rd, mem_addr}, {15'd0, 1'b1, 16'd0});
        chk("f1_rdreg", {dReadReg, dWriteReg, 1'b0, OPMode}, 32'h0000_0000);
        wait_done(4000, cyc);
        chk("f1_latency", 32'(cyc), 32'(WIN * NR));
        check_results(base, "f1");
        step();
        chk("f1_done_pulse", {busy, done}, 32'd0);

        // Frame 2: nms, stalled first result, start while busy.
        fill_img();
        base = obs.size();
        res_ready = 1'b0;
        pulse_start(3'd2);
        chk("f2_mode", {OPMode, dReadReg, dWriteReg}, {21'd0, 3'd2, 4'd3, 4'd0});
        step();
        chk("f2_first_wr", {bCE, bWE, InData, dAddrRegRow, dAddrRegCol},
            {10'd0, 2'b00, img[0], 3'd0, 3'd0});
        n = 0;
        while (!res_valid && n < 200) begin
            step();
            n++;
        end
        chk("f2_valid", 32'(res_valid), 32'd1);
        sx = res_x;
        sy = res_y;
        sd = res_data;
        chk("f2_first", {sx, sy, sd}, {8'd2, 8'd2, 8'(model(2, 2))});
        for (int i = 0; i < 10; i++) begin
            start   = (i == 4);
            op_mode = (i == 4) ? 3'd3 : 3'd2;
            step();
            chk("f2_hold", {res_valid, res_x, res_y, res_data, mem_rd},
                {6'd0, 1'b1, sx, sy, sd, 1'b0});
        end
        start = 1'b0;
        chk("f2_mode_kept", 32'(OPMode), 32'd2);
        res_ready = 1'b1;
        wait_done(4000, cyc);
        check_results(base, "f2");
        step();

        // Frame 3: hyst, reset during RUN, then rescan in sobel mode.
        fill_img();
        pulse_start(3'd3);
        chk("f3_rdreg", 32'(dReadReg), 32'd4);
        n = 0;
        while (bOPEnable && n < 200) begin
            step();
            n++;
        end
        chk("f3_in_run", 32'(bOPEnable), 32'd0);
        rst = 1'b1;
        step();
        chk("f3_abort", {bOPEnable, bCE, busy, res_valid, mem_rd},
            {27'd0, 5'b11000});
        rst = 1'b0;
        step();
        chk("f3_idle", 32'(busy), 32'd0);
        base = obs.size();
        pulse_start(3'd1);
        chk("f3_rescan", {dReadReg, mem_rd, mem_addr}, {11'd0, 4'd1, 1'b1, 16'd0});
        wait_done(4000, cyc);
        check_results(base, "f3");
        step();

        chk("protocol", 32'(prot), 32'd0);
        chk("mem_range", 32'(oob), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
